// File: rtl/chan_pkg.sv
// chan_pkg: K-characters, FSM states and shared helpers for chan_arbiter.
package chan_pkg;
  localparam logic [7:0] K_COMMA  = 8'hBC;
  localparam logic [7:0] K_TRIG   = 8'h1C;
  localparam logic [7:0] K_ABORT  = 8'h7C;
  localparam logic [7:0] COMMA_HI = 8'h50;
  typedef enum logic [1:0] {IDLE, HDR, PAY, DONE} state_e;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating priority encoder, first set request at or after ptr.
module rr_pick #(
  parameter int N  = 16,
  parameter int PW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          vld
);
  logic [PW-1:0] j;
  always_comb begin
    idx = '0;
    j   = '0;
    vld = |req;
    // scan farthest to nearest so the closest requester after ptr wins
    for (int i = N - 1; i >= 0; i--) begin
      j = PW'((int'(ptr) + i) % N);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/chan_arbiter.sv
// chan_arbiter: round-robin merger of channel blocks onto one GTP lane,
// with trigger K-char insertion, truncation and abort signalling.
module chan_arbiter
  import chan_pkg::*;
#(
  parameter int NCH       = 16,
  parameter int DW        = 16,
  parameter int LENW      = 12,
  parameter int MAX_WORDS = 511
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  output logic [NCH-1:0]    ack,
  input  logic [NCH*DW-1:0] din,
  input  logic [NCH-1:0]    ch_mask,
  input  logic              trig_in,
  output logic [DW-1:0]     tx_data,
  output logic [DW/8-1:0]   tx_k,
  output logic              busy,
  output logic [15:0]       err_cnt
);
  localparam int PW = $clog2(NCH);
  localparam logic [DW-1:0]   COMMA_W = DW'({COMMA_HI, K_COMMA});
  localparam logic [DW-1:0]   ABORT_W = DW'({8'h00, K_ABORT});
  localparam logic [DW/8-1:0] K_LO    = (DW/8)'(1);
  localparam logic [LENW-1:0] MAXL    = LENW'(MAX_WORDS);
  state_e          state_q, state_d;
  logic [PW-1:0]   g_q, g_d, ptr_q, ptr_d, pick_idx, nxt_ptr;
  logic [LENW-1:0] cnt_q, cnt_d, hdr_len;
  logic            trunc_q, trunc_d, pick_vld, req_g;
  logic [DW-1:0]   tx_data_q, tx_data_d, din_g;
  logic [DW/8-1:0] tx_k_q, tx_k_d;
  logic [15:0]     err_q, err_d;
  logic [7:0]      tcnt_q, tcnt_d;
  rr_pick #(.N(NCH), .PW(PW)) u_pick (
    .req(req & ch_mask),
    .ptr(ptr_q),
    .idx(pick_idx),
    .vld(pick_vld)
  );
  assign din_g   = DW'(din >> (g_q * DW));
  assign hdr_len = din_g[LENW-1:0];
  assign req_g   = req[g_q];
  assign nxt_ptr = (g_q == PW'(NCH - 1)) ? '0 : g_q + PW'(1);
  assign tx_data = tx_data_q;
  assign tx_k    = tx_k_q;
  assign err_cnt = err_q;
  assign busy    = (state_q == HDR) || (state_q == PAY);
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    trunc_d   = trunc_q;
    tx_data_d = COMMA_W;
    tx_k_d    = K_LO;
    err_d     = err_q;
    tcnt_d    = tcnt_q;
    ack       = '0;
    // a trigger freezes the FSM for the cycle so the block resumes intact
    if (trig_in) begin
      tx_data_d = DW'({tcnt_q, K_TRIG});
      tcnt_d    = tcnt_q + 8'd1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = pick_vld ? HDR : IDLE;
          g_d     = pick_vld ? pick_idx : g_q;
        end
        HDR, PAY: begin
          if (!req_g) begin
            tx_data_d = ABORT_W;
            err_d     = sat_inc(err_q);
            ptr_d     = nxt_ptr;
            state_d   = IDLE;
          end else begin
            ack[g_q]  = 1'b1;
            tx_data_d = din_g;
            tx_k_d    = '0;
            if (state_q == HDR) begin
              trunc_d = hdr_len > MAXL;
              cnt_d   = trunc_d ? MAXL : hdr_len;
              state_d = (cnt_d == '0) ? DONE : PAY;
            end else begin
              cnt_d   = cnt_q - LENW'(1);
              state_d = (cnt_q == LENW'(1)) ? DONE : PAY;
            end
          end
        end
        DONE: begin
          tx_data_d = trunc_q ? ABORT_W : COMMA_W;
          err_d     = trunc_q ? sat_inc(err_q) : err_q;
          ptr_d     = nxt_ptr;
          trunc_d   = 1'b0;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      g_q       <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      trunc_q   <= 1'b0;
      tx_data_q <= COMMA_W;
      tx_k_q    <= K_LO;
      err_q     <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      trunc_q   <= trunc_d;
      tx_data_q <= tx_data_d;
      tx_k_q    <= tx_k_d;
      err_q     <= err_d;
      tcnt_q    <= tcnt_d;
    end
  end
endmodule

// File: tb/tb_chan_arbiter.sv
// tb_chan_arbiter: directed plus random stimulus against a block-queue reference model.
module tb_chan_arbiter;
  localparam int NCH  = 16;
  localparam int MAXW = 511;
  logic clk = 1'b0;
  logic rst_n;
  logic [NCH-1:0] req, ack, ch_mask;
  logic [NCH*16-1:0] din;
  logic trig_in, busy;
  logic [15:0] tx_data, err_cnt;
  logic [1:0] tx_k;
  chan_arbiter #(.NCH(NCH), .DW(16), .LENW(12), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .din(din), .ch_mask(ch_mask),
    .trig_in(trig_in), .tx_data(tx_data), .tx_k(tx_k), .busy(busy), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] d;
    logic [1:0]  k;
    int          ch;
  } ent_t;
  ent_t q[$];
  int gseq[$];
  logic [15:0] blk [NCH][521];
  int pos [NCH];
  int need [NCH];
  int nack [NCH];
  int m_ptr, m_cur, m_err;
  logic [7:0] m_tcnt;
  logic [15:0] e_tx, e_ack;
  logic [1:0] e_k;
  logic e_busy;
  logic [NCH-1:0] ack_s, ack_last;
  int npass = 0;
  int nchk = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic model_reset();
    q.delete();
    m_ptr = 0; m_cur = 0; m_err = 0; m_tcnt = 8'd0; ack_last = '0;
  endtask
  // expected output of a whole granted block: header, payload, then terminator
  task automatic start_block(input int c);
    int len, n;
    len = int'(blk[c][0][11:0]);
    n = (len > MAXW) ? MAXW : len;
    for (int i = 0; i <= n; i++) q.push_back('{blk[c][i], 2'b00, c});
    q.push_back('{(len > MAXW) ? 16'h007C : 16'h50BC, 2'b01, -1});
    m_cur = c;
  endtask
  task automatic model_step();
    ent_t e;
    int c;
    e_ack = '0;
    e_busy = (q.size() > 0) && (q[0].ch >= 0);
    if (trig_in) begin
      e_tx = {m_tcnt, 8'h1C}; e_k = 2'b01; m_tcnt = m_tcnt + 8'd1;
    end else if (q.size() > 0) begin
      if (q[0].ch >= 0 && !req[q[0].ch]) begin
        e_tx = 16'h007C; e_k = 2'b01;
        m_err = (m_err < 65535) ? m_err + 1 : m_err;
        m_ptr = (m_cur + 1) % NCH;
        q.delete();
      end else begin
        e = q.pop_front();
        e_tx = e.d; e_k = e.k;
        if (e.ch >= 0) e_ack[e.ch] = 1'b1;
        else begin
          m_ptr = (m_cur + 1) % NCH;
          if (e.d == 16'h007C) m_err = (m_err < 65535) ? m_err + 1 : m_err;
        end
      end
    end else begin
      e_tx = 16'h50BC; e_k = 2'b01;
      for (int i = 0; i < NCH; i++) begin
        c = (m_ptr + i) % NCH;
        if (req[c] && ch_mask[c]) begin
          start_block(c);
          break;
        end
      end
    end
  endtask
  task automatic load(input int ch, input int len);
    int n;
    n = (len > MAXW) ? MAXW : len;
    blk[ch][0] = {4'($urandom), 12'(len)};
    for (int i = 1; i <= n; i++) blk[ch][i] = 16'($urandom);
    pos[ch] = 0; need[ch] = n + 1; req[ch] = 1'b1;
  endtask
  task automatic tick();
    for (int c = 0; c < NCH; c++) din[c*16 +: 16] = blk[c][pos[c]];
    @(negedge clk);
    model_step();
    chk("ack", 32'(ack), 32'(e_ack));
    chk("busy", 32'(busy), 32'(e_busy));
    ack_s = ack;
    @(posedge clk);
    #1;
    chk("tx_data", 32'(tx_data), 32'(e_tx));
    chk("tx_k", 32'(tx_k), 32'(e_k));
    chk("err_cnt", 32'(err_cnt), m_err);
    for (int c = 0; c < NCH; c++) begin
      if (ack_s[c]) begin
        if (pos[c] < 520) pos[c]++;
        nack[c]++;
        if (pos[c] == need[c]) req[c] = 1'b0;
        if (ack_last == '0) gseq.push_back(c);
      end
    end
    ack_last = ack_s;
  endtask
  task automatic wait_pos(input int ch, input int p);
    for (int i = 0; i < 60 && pos[ch] != p; i++) tick();
    chk("wait_pos", pos[ch], p);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int a;
    bit dropped;
    rst_n = 1'b0; req = '0; ch_mask = '1; trig_in = 1'b0; din = '0;
    for (int c = 0; c < NCH; c++) begin
      pos[c] = 0; need[c] = 0; nack[c] = 0;
      for (int i = 0; i < 521; i++) blk[c][i] = 16'h0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_tx", 32'(tx_data), 32'h50BC);
    chk("rst_k", 32'(tx_k), 32'h1);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    load(3, 4);
    repeat (8) tick();
    chk("t1_acks", nack[3], 5);
    gseq.delete();
    load(2, 1); load(5, 1);
    repeat (8) tick();
    chk("t1_ngrant", gseq.size(), 2);
    chk("t1_first", (gseq.size() > 0) ? gseq[0] : -1, 5);
    chk("t1_second", (gseq.size() > 1) ? gseq[1] : -1, 2);
    load(14, 0);
    repeat (5) tick();
    gseq.delete();
    load(0, 2); load(15, 2);
    repeat (12) tick();
    chk("t2_ngrant", gseq.size(), 2);
    chk("t2_first", (gseq.size() > 0) ? gseq[0] : -1, 15);
    chk("t2_second", (gseq.size() > 1) ? gseq[1] : -1, 0);
    ch_mask[0] = 1'b0;
    a = nack[0];
    load(0, 1); load(1, 1);
    repeat (8) tick();
    chk("t2_masked", nack[0], a);
    chk("t2_other", nack[1], 2);
    req[0] = 1'b0; ch_mask = '1;
    load(6, 6);
    wait_pos(6, 2);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    chk("t3_trig0", 32'(tx_data), 32'h001C);
    chk("t3_trig0_ack", 32'(ack_s), 0);
    wait_pos(6, 5);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    chk("t3_trig1", 32'(tx_data), 32'h011C);
    repeat (6) tick();
    chk("t3_acks", nack[6], 7);
    a = nack[7];
    load(7, 600);
    repeat (520) tick();
    chk("t4_err", 32'(err_cnt), 1);
    chk("t4_acks", nack[7] - a, 512);
    load(5, 8);
    wait_pos(5, 3);
    load(9, 1);
    req[5] = 1'b0;
    tick();
    chk("t5_abort", 32'(tx_data), 32'h007C);
    chk("t5_err", 32'(err_cnt), 2);
    chk("t5_ack", 32'(ack_s), 0);
    gseq.delete();
    repeat (6) tick();
    chk("t5_next", (gseq.size() > 0) ? gseq[0] : -1, 9);
    load(4, 8);
    wait_pos(4, 3);
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("t6_ack", 32'(ack), 0);
    chk("t6_tx", 32'(tx_data), 32'h50BC);
    chk("t6_k", 32'(tx_k), 32'h1);
    chk("t6_err", 32'(err_cnt), 0);
    chk("t6_busy", 32'(busy), 0);
    #2;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < NCH; c++) pos[c] = 0;
    gseq.delete();
    load(7, 1); load(2, 1);
    repeat (6) tick();
    chk("t6_first", (gseq.size() > 0) ? gseq[0] : -1, 2);
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) ch_mask = 16'($urandom) | 16'h0F0F;
      for (int c = 0; c < NCH; c++)
        if (!req[c] && $urandom_range(0, 7) == 0) load(c, int'($urandom_range(0, 6)));
      dropped = 1'b0;
      for (int c = 0; c < NCH; c++)
        if (req[c] && pos[c] > 0 && pos[c] < need[c] && $urandom_range(0, 199) == 0) begin
          req[c] = 1'b0;
          dropped = 1'b1;
        end
      trig_in = !dropped && ($urandom_range(0, 9) == 0);
      tick();
    end
    trig_in = 1'b0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
